soft_trig_receiver: RTL and testbench

Trigger-clock-domain endpoint for software-issued triggers. It accepts the single-cycle soft-trigger flags produced by the control-domain soft trigger generator after they cross into the trigger clock. It queues up to 7 outstanding triggers and presents them one at a time to the trigger handler over a req/ack handshake, with a programmable minimum spacing between issues. It also keeps an issued count, a sticky overflow flag and a status byte that the control side reads back to confirm that its soft-trigger bursts were delivered.

---
 rtl/soft_trig_receiver_if.sv | 26 ++
 rtl/soft_trig_receiver.sv | 121 ++++++++++++
 tb/tb_soft_trig_receiver.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/soft_trig_receiver_if.sv
// Handshake and status bundle between the soft-trigger receiver and its trigger handler.
interface soft_trig_receiver_if #(
    parameter int unsigned CNT_WIDTH = 16
);
    logic                 trig_i;
    logic                 enable_i;
    logic                 clear_i;
    logic                 trig_ack_i;
    logic                 trig_req_o;
    logic [2:0]           pending_o;
    logic [CNT_WIDTH-1:0] issued_count_o;
    logic                 dropped_o;
    logic [7:0]           status_o;

    // Receiver side: issues requests and reports status.
    modport master (
        input  trig_i, enable_i, clear_i, trig_ack_i,
        output trig_req_o, pending_o, issued_count_o, dropped_o, status_o
    );

    // Handler/control side: supplies triggers and acknowledges.
    modport slave (
        output trig_i, enable_i, clear_i, trig_ack_i,
        input  trig_req_o, pending_o, issued_count_o, dropped_o, status_o
    );
endinterface

// File: rtl/soft_trig_receiver.sv
// Trigger-domain endpoint for soft triggers: 7-deep pending counter, req/ack issue
// FSM with programmable holdoff, issued counter, sticky drop flag and status byte.
module soft_trig_receiver #(
    parameter int unsigned HOLDOFF   = 4,
    parameter int unsigned CNT_WIDTH = 16
) (
    input logic                  trigclk_i,
    input logic                  rst_n_i,
    soft_trig_receiver_if.master bus
);
    localparam int unsigned PEND_W = 3;
    localparam int unsigned HOLD_W = 8;
    localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(7);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [HOLD_W-1:0]     hold_cnt_next;
    logic                  req_q;
    logic [PEND_W-1:0]     pending;
    logic [CNT_WIDTH-1:0]  issued;
    logic                  dropped;
    logic                  inc;
    logic                  dec;

    // A trigger only counts when enabled; a request retires only while it is raised.
    assign inc = bus.trig_i & bus.enable_i;
    assign dec = req_q & bus.trig_ack_i;

    // Pending queue depth, issued counter and sticky overflow flag.
    always_ff @(posedge trigclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pending <= '0;
            issued  <= '0;
            dropped <= 1'b0;
        end else if (bus.clear_i) begin
            pending <= '0;
            issued  <= '0;
            dropped <= 1'b0;
        end else begin
            if (inc && !dec) begin
                if (pending != PEND_MAX) begin
                    pending <= pending + PEND_W'(1);
                end else begin
                    dropped <= 1'b1;
                end
            end else if (dec && !inc) begin
                pending <= pending - PEND_W'(1);
            end
            if (dec) begin
                issued <= issued + CNT_WIDTH'(1);
            end
        end
    end

    // Issue FSM state, holdoff counter and registered request.
    always_ff @(posedge trigclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= IDLE;
            hold_cnt <= '0;
            req_q    <= 1'b0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_cnt_next;
            req_q    <= (state_next == REQ);
        end
    end

    // Next-state logic: raise a request per queued trigger, then enforce holdoff.
    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        case (state)
            IDLE: begin
                if (pending != '0) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (bus.trig_ack_i) begin
                    if (HOLD_LOAD == '0) begin
                        state_next = IDLE;
                    end else begin
                        state_next    = HOLD;
                        hold_cnt_next = HOLD_LOAD;
                    end
                end
            end
            HOLD: begin
                if (hold_cnt <= HOLD_W'(1)) begin
                    state_next    = IDLE;
                    hold_cnt_next = '0;
                end else begin
                    hold_cnt_next = hold_cnt - HOLD_W'(1);
                end
            end
            default: begin
                state_next    = IDLE;
                hold_cnt_next = '0;
            end
        endcase
        if (bus.clear_i) begin
            state_next    = IDLE;
            hold_cnt_next = '0;
        end
    end

    // Outputs; only the enable bit of status is a live input.
    assign bus.trig_req_o     = req_q;
    assign bus.pending_o      = pending;
    assign bus.issued_count_o = issued;
    assign bus.dropped_o      = dropped;
    assign bus.status_o       = {dropped, req_q, (state == HOLD), bus.enable_i, 1'b0, pending};
endmodule

// File: tb/tb_soft_trig_receiver.sv
// Bench for soft_trig_receiver: two instances (HOLDOFF=4/16-bit count, HOLDOFF=0/4-bit
// count) share one stimulus stream and are compared every cycle against a
// time-based reference model, plus directed scenario checks.
module tb_soft_trig_receiver;
    logic clk = 1'b0;
    logic rst_n;
    logic trig, en, clr, ack;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    soft_trig_receiver_if #(.CNT_WIDTH(16)) if0 ();
    soft_trig_receiver_if #(.CNT_WIDTH(4))  if1 ();

    assign if0.trig_i     = trig;
    assign if0.enable_i   = en;
    assign if0.clear_i    = clr;
    assign if0.trig_ack_i = ack;
    assign if1.trig_i     = trig;
    assign if1.enable_i   = en;
    assign if1.clear_i    = clr;
    assign if1.trig_ack_i = ack;

    soft_trig_receiver #(.HOLDOFF(4), .CNT_WIDTH(16)) dut0 (
        .trigclk_i (clk),
        .rst_n_i   (rst_n),
        .bus       (if0)
    );

    soft_trig_receiver #(.HOLDOFF(0), .CNT_WIDTH(4)) dut1 (
        .trigclk_i (clk),
        .rst_n_i   (rst_n),
        .bus       (if1)
    );

    // Reference model: queue depth, request flag and the earliest edge a new
    // request may rise, all derived from the acknowledge time.
    int     h_of[2];
    int     mod_of[2];
    int     m_pend[2];
    bit     m_req[2];
    bit     m_drop[2];
    int     m_cnt[2];
    longint m_next[2];
    longint m_hold_end[2];
    longint cur;
    bit     prev_req[2];
    longint rises0[$];
    longint rises1[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pend[d]     = 0;
            m_req[d]      = 1'b0;
            m_drop[d]     = 1'b0;
            m_cnt[d]      = 0;
            m_next[d]     = 0;
            m_hold_end[d] = 0;
        end
    endtask

    task automatic model_edge();
        bit inc, dec;
        int old;
        cur++;
        for (int d = 0; d < 2; d++) begin
            if (clr) begin
                m_pend[d]     = 0;
                m_cnt[d]      = 0;
                m_drop[d]     = 1'b0;
                m_req[d]      = 1'b0;
                m_next[d]     = 0;
                m_hold_end[d] = 0;
            end else begin
                inc = trig && en;
                dec = m_req[d] && ack;
                old = m_pend[d];
                if (inc && !dec) begin
                    if (m_pend[d] < 7) m_pend[d]++;
                    else m_drop[d] = 1'b1;
                end else if (dec && !inc) begin
                    m_pend[d]--;
                end
                if (dec) begin
                    m_cnt[d]      = (m_cnt[d] + 1) % mod_of[d];
                    m_req[d]      = 1'b0;
                    m_next[d]     = cur + h_of[d] + 1;
                    m_hold_end[d] = cur + h_of[d];
                end else if (!m_req[d] && old > 0 && cur >= m_next[d]) begin
                    m_req[d] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [7:0]  st;
        logic        o_req, o_drop;
        logic [2:0]  o_pend;
        logic [31:0] o_cnt;
        logic [7:0]  o_st;
        for (int d = 0; d < 2; d++) begin
            st = {m_drop[d], m_req[d], (cur < m_hold_end[d]), en, 1'b0, 3'(m_pend[d])};
            o_req  = (d == 0) ? if0.trig_req_o : if1.trig_req_o;
            o_drop = (d == 0) ? if0.dropped_o  : if1.dropped_o;
            o_pend = (d == 0) ? if0.pending_o  : if1.pending_o;
            o_cnt  = (d == 0) ? 32'(if0.issued_count_o) : 32'(if1.issued_count_o);
            o_st   = (d == 0) ? if0.status_o   : if1.status_o;
            check($sformatf("d%0d_req@%0d", d, cur),    32'(o_req),  32'(m_req[d]));
            check($sformatf("d%0d_pend@%0d", d, cur),   32'(o_pend), 32'(m_pend[d]));
            check($sformatf("d%0d_count@%0d", d, cur),  o_cnt,       32'(m_cnt[d]));
            check($sformatf("d%0d_drop@%0d", d, cur),   32'(o_drop), 32'(m_drop[d]));
            check($sformatf("d%0d_status@%0d", d, cur), 32'(o_st),   32'(st));
            if (o_req && !prev_req[d]) begin
                if (d == 0) rises0.push_back(cur);
                else rises1.push_back(cur);
            end
            prev_req[d] = o_req;
        end
    endtask

    // One clock: drive inputs, step the model at the edge, compare at the falling edge.
    task automatic cycle(input logic t, input logic e, input logic c, input logic a);
        trig = t;
        en   = e;
        clr  = c;
        ack  = a;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        h_of[0] = 4;  mod_of[0] = 65536;
        h_of[1] = 0;  mod_of[1] = 16;
        cur = 0;
        prev_req[0] = 1'b0;
        prev_req[1] = 1'b0;
        model_reset();
        rst_n = 1'b0;
        trig = 1'b0; en = 1'b1; clr = 1'b0; ack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_all();
        check("rst_status0", 32'(if0.status_o), 32'h10);
        check("rst_status1", 32'(if1.status_o), 32'h10);

        // Basic path with ack tied high.
        cycle(1, 1, 0, 1);
        check("basic_pend_e1", 32'(if0.pending_o), 32'd1);
        cycle(0, 1, 0, 1);
        check("basic_req_e2", 32'(if0.trig_req_o), 32'd1);
        cycle(0, 1, 0, 1);
        check("basic_req_e3", 32'(if0.trig_req_o), 32'd0);
        check("basic_cnt_e3", 32'(if0.issued_count_o), 32'd1);
        repeat (8) cycle(0, 1, 0, 1);
        rises0.delete();
        cycle(1, 1, 0, 1);
        cycle(1, 1, 0, 1);
        repeat (16) cycle(0, 1, 0, 1);
        check("spacing_n", 32'(rises0.size()), 32'd2);
        if (rises0.size() >= 2) check("spacing_h4", 32'(rises0[1] - rises0[0]), 32'd6);

        // Overflow: nine triggers against a stalled handler, then drain.
        cycle(0, 1, 1, 0);
        repeat (9) cycle(1, 1, 0, 0);
        check("ovf_pend", 32'(if0.pending_o), 32'd7);
        check("ovf_drop", 32'(if0.dropped_o), 32'd1);
        check("ovf_status", 32'(if0.status_o), 32'({1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd7}));
        repeat (45) cycle(0, 1, 0, 1);
        check("drain_cnt0", 32'(if0.issued_count_o), 32'd7);
        check("drain_pend0", 32'(if0.pending_o), 32'd0);
        check("drain_drop0", 32'(if0.dropped_o), 32'd1);
        check("drain_cnt1", 32'(if1.issued_count_o), 32'd7);

        // Trigger coincident with ack at full queue.
        cycle(0, 1, 1, 0);
        repeat (7) cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 1);
        check("sim_pend", 32'(if0.pending_o), 32'd7);
        check("sim_drop", 32'(if0.dropped_o), 32'd0);
        check("sim_cnt", 32'(if0.issued_count_o), 32'd1);

        // Disabled trigger is ignored.
        cycle(1, 0, 0, 0);
        check("dis_pend", 32'(if0.pending_o), 32'd7);
        check("dis_drop", 32'(if0.dropped_o), 32'd0);

        // Clear during an active request with a coincident ack.
        cycle(0, 1, 1, 0);
        repeat (5) cycle(1, 1, 0, 1);
        repeat (30) cycle(0, 1, 0, 1);
        repeat (2) cycle(1, 1, 0, 0);
        repeat (2) cycle(0, 1, 0, 0);
        check("pre_clr_req", 32'(if0.trig_req_o), 32'd1);
        check("pre_clr_pend", 32'(if0.pending_o), 32'd2);
        check("pre_clr_cnt", 32'(if0.issued_count_o), 32'd5);
        cycle(1, 1, 1, 1);
        check("clr_req", 32'(if0.trig_req_o), 32'd0);
        check("clr_pend", 32'(if0.pending_o), 32'd0);
        check("clr_cnt", 32'(if0.issued_count_o), 32'd0);

        // Counter wrap and 2-cycle spacing on the zero-holdoff instance.
        cycle(0, 1, 1, 0);
        rises1.delete();
        for (int i = 0; i < 34; i++) cycle(((i % 2) == 0), 1, 0, 1);
        repeat (6) cycle(0, 1, 0, 1);
        check("wrap_cnt", 32'(if1.issued_count_o), 32'd1);
        check("wrap_rises", 32'(rises1.size()), 32'd17);
        for (int i = 1; i < rises1.size(); i++) begin
            check($sformatf("wrap_gap%0d", i), 32'(rises1[i] - rises1[i-1]), 32'd2);
        end

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 90),
                  ($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 50));
        end

        // Asynchronous reset in the middle of a request.
        cycle(0, 1, 1, 0);
        repeat (3) cycle(1, 1, 0, 0);
        cycle(0, 1, 0, 0);
        check("prerst_req", 32'(if0.trig_req_o), 32'd1);
        check("prerst_pend", 32'(if0.pending_o), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req0", 32'(if0.trig_req_o), 32'd0);
        check("arst_req1", 32'(if1.trig_req_o), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        trig = 1'b0; en = 1'b1; clr = 1'b0; ack = 1'b0;
        #1;
        check_all();
        check("post_rst_status", 32'(if0.status_o), 32'h10);
        check("post_rst_cnt", 32'(if0.issued_count_o), 32'd0);
        repeat (4) cycle(0, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
